hpm_counters: RTL and testbench
===============================

# hpm_counters

Parametrised hardware performance-monitor unit for the rv64i-zicsr core. It owns `mcycle`, `minstret`, `NUM_HPM` programmable `mhpmcounter`/`mhpmevent` pairs, `mcountinhibit`, `mcounteren`/`scounteren`, and the user-level read-only shadows `cycle`/`time`/`instret`/`hpmcounter*`. It sits beside the CSR file on the same CSR read/write bus. Unlike the fixed counters in the CSR file, it adds:

- per-counter event selection;
- counting inhibit, globally and per privilege mode;
- counter-enable gating of lower-privilege reads;
- a sticky overflow flag per counter and an overflow interrupt.

## Interface
Parameters:
- `NUM_HPM`, default 4: number of implemented HPM counters, legal range 0..29. Counter i maps to `mhpmcounter(3+i)`.
- `NUM_EVENTS`, default 8: width of the `events` input, legal range 1..255.
- `COUNTER_WIDTH`, default 64: HPM counter width, legal range 32..64. `mcycle` and `minstret` are always 64 bits wide.

Ports:
- `phi2` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `priv_level` in 2: current privilege level (0 = U, 1 = S, 3 = M).
- `read` in 1: CSR read strobe.
- `write` in 1: CSR write strobe.
- `csr_addr` in 12: CSR address.
- `data_in` in 64: CSR write data.
- `data_out` out 64: CSR read data. Combinational. 0 when there is no valid read hit.
- `hit` out 1: `csr_addr` lies in this block's address map. Combinational.
- `invalid` out 1: illegal access. Combinational.
- `retire` in 1: one instruction retired this cycle.
- `time_in` in 64: platform `mtime`, returned for `time` reads.
- `events` in `NUM_EVENTS`: event pulses for this cycle. Bit k is event number k+1.
- `overflow_irq` out 1: local counter-overflow interrupt request. Registered.

## Operation
Address map. `hit` = 1 for:
- 0x106 `scounteren`, 0x306 `mcounteren`, 0x320 `mcountinhibit`;
- 0x323..0x33F `mhpmevent3..31`;
- 0xB00 `mcycle`, 0xB02..0xB1F `minstret`/`mhpmcounter`;
- 0xC00..0xC1F user shadows.

All other addresses: `hit` = 0, `invalid` = 0, `data_out` = 0.

Access checks. `invalid` = 1 when `hit` and any of the following hold:
- `(read | write)` and `priv_level < csr_addr[9:8]`;
- `write` and `csr_addr[11:10] == 2'b11`;
- `read` of shadow 0xC00+j with `mcounteren[j] == 0` at S or U;
- `read` of shadow 0xC00+j with `scounteren[j] == 0` at U.

An invalid access returns `data_out` = 0 and changes no state.

Unimplemented counters (index >= 3+`NUM_HPM`, and index 1 on the B-page):
- the counter and its event register read 0;
- writes are ignored;
- the access is not invalid.

`mcountinhibit`:
- bit 0 (CY), bit 2 (IR) and bits 3..3+`NUM_HPM`-1 are writable;
- all other bits, including bit 1 (TM), read 0.

`mcounteren` / `scounteren`:
- 32-bit, stored in the same implemented-bit mask;
- bit 1 is also writable;
- bits 63:32 read 0.

`mhpmevent` layout (WARL):
- [63] OF: sticky overflow flag, software-writable;
- [62] MINH, [61] SINH, [60] UINH: inhibit counting while in M, S or U mode respectively;
- [7:0] event select: 0 = never count; k in 1..`NUM_EVENTS` counts on `events[k-1]`; k > `NUM_EVENTS` stores as 0;
- all other bits read 0.

Increment rules, evaluated each cycle:
- `mcycle` += 1 unless CY is set.
- `minstret` += 1 when `retire` and IR is clear.
- HPM counter i += 1 when all of:
  - its event select is non-zero;
  - the selected `events` bit is 1;
  - `mcountinhibit[3+i]` is clear;
  - the mode-inhibit bit for the current `priv_level` is clear.
- A counter increments by at most 1 per cycle.

Width and wrap:
- HPM counters are `COUNTER_WIDTH` bits, zero-extended on read. Writes keep `data_in[COUNTER_WIDTH-1:0]`.
- An HPM increment from all-ones wraps to 0 and sets that counter's OF in the same edge.
- `mcycle`/`minstret` wrap silently.

`overflow_irq` is registered as OR over all implemented OF bits.

## Timing
- Reads are combinational in the same cycle. They return the pre-edge value and never include that cycle's increment.
- Writes take effect at the next `phi2` edge.
- Write vs. increment on the same counter in the same cycle: the write wins, and there is no increment that cycle.
- Write to `mhpmevent` with OF = 0 in the same cycle as a wrap: OF ends 0, the write wins. The counter still wraps to 0.
- Inhibit or select changes affect counting from the cycle after the write edge.
- `overflow_irq` rises one cycle after the edge that sets OF. It falls one cycle after the last OF clears.

Reset (`rst` low, asynchronous):
- all counters, event registers, `mcountinhibit`, `mcounteren` and `scounteren` = 0;
- `overflow_irq` = 0.

Counting resumes on the first edge after `rst` is released. Asserting reset mid-operation discards all counts immediately.

## Test plan
- **Reset.** Drive `rst` low mid-count, then release. Required: all reads return 0 and `overflow_irq` = 0. Read `mcycle` 5 edges after release -> 5.
- **Event counting.** Write `mhpmevent3` = 2 and pulse `events[1]` on 7 cycles. Required: `mhpmcounter3` = 7. `events[0]` pulses do not count.
- **Wrap and overflow.** Set `COUNTER_WIDTH` = 40. Write `mhpmcounter3` = 0xFF_FFFF_FFFF, then apply one event. Required: counter reads 0, `mhpmevent3[63]` = 1, and `overflow_irq` = 1 one cycle later. Write OF = 0 -> `overflow_irq` = 0.
- **Inhibit and mode filter.** Set `mcountinhibit` = 0x5 -> `mcycle`/`minstret` hold. Set UINH with `priv_level` = 0 -> no count; switch to `priv_level` = 3 -> counts.
- **Access gating.** At U, read 0xC00 with `mcounteren` = 1, `scounteren` = 0 -> `invalid` = 1. Set `scounteren` = 1 -> returns `mcycle`. Write 0xC00 -> `invalid`. At S, access 0xB00 -> `invalid`.
- **Write-vs-increment collision.** Write `minstret` = 100 in a cycle with `retire` = 1. Required: reads 100 next cycle. Read of unimplemented 0xB1F -> 0, `invalid` = 0.

Source files
------------

// File: rtl/hpm_counters.sv
// Performance-monitor unit: mcycle/minstret, programmable HPM counters with event
// select, global and per-mode inhibit, counter-enable read gating and overflow irq.
module hpm_counters #(
   parameter int NUM_HPM       = 4,
   parameter int NUM_EVENTS    = 8,
   parameter int COUNTER_WIDTH = 64
) (
   input  logic                  phi2,
   input  logic                  rst,
   input  logic [1:0]            priv_level,
   input  logic                  read,
   input  logic                  write,
   input  logic [11:0]           csr_addr,
   input  logic [63:0]           data_in,
   output logic [63:0]           data_out,
   output logic                  hit,
   output logic                  invalid,
   input  logic                  retire,
   input  logic [63:0]           time_in,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  overflow_irq
);
   localparam int          NH       = (NUM_HPM == 0) ? 1 : NUM_HPM;
   localparam logic [31:0] HPM_BITS = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
   localparam logic [31:0] INH_MASK = HPM_BITS | 32'h0000_0005;
   localparam logic [31:0] EN_MASK  = INH_MASK | 32'h0000_0002;
   localparam logic [8:0]  NEV      = 9'(NUM_EVENTS);

   function automatic logic event_hit(input logic [7:0] sel, input logic [NUM_EVENTS-1:0] ev);
      logic h;
      h = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++) begin
         h = (sel == 8'(k)) ? ev[k-1] : h;
      end
      return h;
   endfunction

   // inh is {MINH, SINH, UINH}; the reserved level 2 is never filtered
   function automatic logic mode_inhibited(input logic [2:0] inh, input logic [1:0] priv);
      logic m;
      case (priv)
         2'd3:    m = inh[2];
         2'd1:    m = inh[1];
         2'd0:    m = inh[0];
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   logic [63:0]              mcycle_r, minstret_r;
   logic [COUNTER_WIDTH-1:0] hpm_r [NH];
   logic [7:0]               sel_r [NH];
   logic [2:0]               inh_r [NH];
   logic [NH-1:0]            of_r;
   logic [31:0]              inhibit_r, mcen_r, scen_r;
   logic                     irq_r;

   logic [4:0]    idx_s;
   logic          is_scen_s, is_mcen_s, is_inh_s, is_evt_s, is_mcnt_s, is_ucnt_s;
   logic          priv_low_s, ro_wr_s, m_gate_s, s_gate_s, wr_s;
   logic [63:0]   cnt_rd_s, evt_rd_s, rd_s;
   logic [NH-1:0] cnt_wr_s, evt_wr_s, hpm_inc_s, wrap_s;

   assign idx_s     = csr_addr[4:0];
   assign is_scen_s = (csr_addr == 12'h106);
   assign is_mcen_s = (csr_addr == 12'h306);
   assign is_inh_s  = (csr_addr == 12'h320);
   assign is_evt_s  = (csr_addr[11:5] == 7'h19) && (idx_s >= 5'd3);
   assign is_mcnt_s = (csr_addr[11:5] == 7'h58) && (idx_s != 5'd1);
   assign is_ucnt_s = (csr_addr[11:5] == 7'h60);
   assign hit       = is_scen_s | is_mcen_s | is_inh_s | is_evt_s | is_mcnt_s | is_ucnt_s;

   assign priv_low_s = (read | write) && (priv_level < csr_addr[9:8]);
   assign ro_wr_s    = write && (csr_addr[11:10] == 2'b11);
   assign m_gate_s   = read && is_ucnt_s && (priv_level != 2'd3) && !mcen_r[idx_s];
   assign s_gate_s   = read && is_ucnt_s && (priv_level == 2'd0) && !scen_r[idx_s];
   assign invalid    = hit && (priv_low_s | ro_wr_s | m_gate_s | s_gate_s);
   assign wr_s       = write && hit && !invalid;

   // Read-data mux; unimplemented counter slots fall through as zero
   always_comb begin
      evt_rd_s = 64'd0;
      case (idx_s)
         5'd0:    cnt_rd_s = mcycle_r;
         5'd1:    cnt_rd_s = time_in;
         5'd2:    cnt_rd_s = minstret_r;
         default: cnt_rd_s = 64'd0;
      endcase
      for (int i = 0; i < NUM_HPM; i++) begin
         cnt_rd_s = (idx_s == 5'(3 + i)) ? 64'(hpm_r[i]) : cnt_rd_s;
         evt_rd_s = (idx_s == 5'(3 + i)) ? {of_r[i], inh_r[i], 52'd0, sel_r[i]} : evt_rd_s;
      end
      if (is_scen_s) begin
         rd_s = {32'd0, scen_r};
      end else if (is_mcen_s) begin
         rd_s = {32'd0, mcen_r};
      end else if (is_inh_s) begin
         rd_s = {32'd0, inhibit_r};
      end else if (is_evt_s) begin
         rd_s = evt_rd_s;
      end else if (is_mcnt_s || is_ucnt_s) begin
         rd_s = cnt_rd_s;
      end else begin
         rd_s = 64'd0;
      end
   end

   assign data_out = (read && hit && !invalid) ? rd_s : 64'd0;

   // Per-counter write strobes, increment qualifiers and wrap detection
   always_comb begin
      cnt_wr_s  = '0;
      evt_wr_s  = '0;
      hpm_inc_s = '0;
      wrap_s    = '0;
      for (int i = 0; i < NUM_HPM; i++) begin
         cnt_wr_s[i]  = wr_s && is_mcnt_s && (idx_s == 5'(3 + i));
         evt_wr_s[i]  = wr_s && is_evt_s && (idx_s == 5'(3 + i));
         hpm_inc_s[i] = event_hit(sel_r[i], events) && !inhibit_r[3 + i] &&
                        !mode_inhibited(inh_r[i], priv_level);
         wrap_s[i]    = hpm_inc_s[i] && !cnt_wr_s[i] && (&hpm_r[i]);
      end
   end

   // Counter and control state; a software write always beats the same-cycle update
   always_ff @(posedge phi2 or negedge rst) begin
      if (!rst) begin
         mcycle_r   <= 64'd0;
         minstret_r <= 64'd0;
         inhibit_r  <= 32'd0;
         mcen_r     <= 32'd0;
         scen_r     <= 32'd0;
         of_r       <= '0;
         irq_r      <= 1'b0;
         for (int i = 0; i < NH; i++) begin
            hpm_r[i] <= '0;
            sel_r[i] <= 8'd0;
            inh_r[i] <= 3'd0;
         end
      end else begin
         if (wr_s && is_scen_s) scen_r <= data_in[31:0] & EN_MASK;
         if (wr_s && is_mcen_s) mcen_r <= data_in[31:0] & EN_MASK;
         if (wr_s && is_inh_s) inhibit_r <= data_in[31:0] & INH_MASK;

         if (wr_s && is_mcnt_s && (idx_s == 5'd0)) mcycle_r <= data_in;
         else if (!inhibit_r[0]) mcycle_r <= mcycle_r + 64'd1;

         if (wr_s && is_mcnt_s && (idx_s == 5'd2)) minstret_r <= data_in;
         else if (retire && !inhibit_r[2]) minstret_r <= minstret_r + 64'd1;

         for (int i = 0; i < NUM_HPM; i++) begin
            if (cnt_wr_s[i]) hpm_r[i] <= data_in[COUNTER_WIDTH-1:0];
            else if (hpm_inc_s[i]) hpm_r[i] <= hpm_r[i] + 1'b1;

            if (evt_wr_s[i]) begin
               sel_r[i] <= ({1'b0, data_in[7:0]} <= NEV) ? data_in[7:0] : 8'd0;
               inh_r[i] <= data_in[62:60];
               of_r[i]  <= data_in[63];
            end else if (wrap_s[i]) begin
               of_r[i] <= 1'b1;
            end
         end

         irq_r <= |of_r;
      end
   end

   assign overflow_irq = irq_r;

endmodule

// File: tb/tb_hpm_counters.sv
// Scoreboard bench for hpm_counters: the driver queues expected CSR responses,
// a negedge monitor pops and compares them whenever an access is presented.
module tb_hpm_counters;
   logic        phi2 = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  priv_level = 2'd3;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [11:0] csr_addr = 12'h000;
   logic [63:0] data_in = 64'd0;
   logic [63:0] data_out;
   logic        hit, invalid;
   logic        retire = 1'b0;
   logic [63:0] time_in = 64'h1234_5678_9ABC_DEF0;
   logic [7:0]  events = 8'h00;
   logic        overflow_irq;

   hpm_counters #(.NUM_HPM(4), .NUM_EVENTS(8), .COUNTER_WIDTH(40)) dut (
      .phi2(phi2), .rst(rst), .priv_level(priv_level), .read(read), .write(write),
      .csr_addr(csr_addr), .data_in(data_in), .data_out(data_out), .hit(hit),
      .invalid(invalid), .retire(retire), .time_in(time_in), .events(events),
      .overflow_irq(overflow_irq)
   );

   always #5 phi2 = ~phi2;

   typedef struct {
      logic [63:0] data;
      logic        inv;
      logic        hit;
      logic        irq;
      int          id;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   step = 0;

   task automatic chk(input int id, input string what, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL step%0d %s: got %h expected %h", id, what, act, expv);
      end
   endtask

   // Monitor: every presented access consumes one expected entry
   always @(negedge phi2) begin
      if (read || write) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: addr %h with empty scoreboard", csr_addr);
         end else begin
            mon_e = sbq.pop_front();
            chk(mon_e.id, "data_out", data_out, mon_e.data);
            chk(mon_e.id, "invalid", 64'(invalid), 64'(mon_e.inv));
            chk(mon_e.id, "hit", 64'(hit), 64'(mon_e.hit));
            chk(mon_e.id, "overflow_irq", 64'(overflow_irq), 64'(mon_e.irq));
         end
      end
   end

   task automatic acc(input logic rd_en, input logic wr_en, input logic [11:0] addr,
                      input logic [63:0] wd, input logic [7:0] ev, input logic [63:0] exp_d,
                      input logic exp_inv, input logic exp_hit, input logic exp_irq);
      exp_t e;
      @(posedge phi2);
      #1;
      read     = rd_en;
      write    = wr_en;
      csr_addr = addr;
      data_in  = wd;
      events   = ev;
      step++;
      e.data = exp_d;
      e.inv  = exp_inv;
      e.hit  = exp_hit;
      e.irq  = exp_irq;
      e.id   = step;
      sbq.push_back(e);
      @(posedge phi2);
      #1;
      read   = 1'b0;
      write  = 1'b0;
      events = 8'h00;
   endtask

   task automatic rd(input logic [11:0] addr, input logic [63:0] exp_d, input logic exp_inv, input logic exp_irq);
      acc(1'b1, 1'b0, addr, 64'd0, 8'h00, exp_d, exp_inv, 1'b1, exp_irq);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [63:0] wd, input logic exp_inv, input logic exp_irq);
      acc(1'b0, 1'b1, addr, wd, 8'h00, 64'd0, exp_inv, 1'b1, exp_irq);
   endtask

   task automatic pulse(input logic [7:0] ev, input int n);
      repeat (n) begin
         @(posedge phi2);
         #1 events = ev;
         @(posedge phi2);
         #1 events = 8'h00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, count a little, then reset again mid-count
      repeat (2) @(posedge phi2);
      #1 rst = 1'b1;
      repeat (3) @(posedge phi2);
      #2 rst = 1'b0;
      rd(12'hB00, 64'd0, 1'b0, 1'b0);
      rd(12'hB02, 64'd0, 1'b0, 1'b0);
      rd(12'h323, 64'd0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (4) @(posedge phi2);
      rd(12'hB00, 64'd5, 1'b0, 1'b0);

      // inhibit: mcycle freezes at 8 from here on
      wr(12'h320, 64'h5, 1'b0, 1'b0);
      wr(12'h320, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      rd(12'h320, 64'h7D, 1'b0, 1'b0);
      wr(12'h320, 64'h5, 1'b0, 1'b0);
      rd(12'h320, 64'h5, 1'b0, 1'b0);
      retire = 1'b1;
      rd(12'hB00, 64'd8, 1'b0, 1'b0);
      rd(12'hB02, 64'd0, 1'b0, 1'b0);
      retire = 1'b0;

      // event selection
      wr(12'h323, 64'd2, 1'b0, 1'b0);
      pulse(8'h02, 7);
      pulse(8'h01, 3);
      rd(12'hB03, 64'd7, 1'b0, 1'b0);
      rd(12'h323, 64'd2, 1'b0, 1'b0);
      rd(12'hB04, 64'd0, 1'b0, 1'b0);
      wr(12'h324, 64'd9, 1'b0, 1'b0);
      rd(12'h324, 64'd0, 1'b0, 1'b0);
      wr(12'h325, 64'h7FFF_FFFF_FFFF_FF05, 1'b0, 1'b0);
      rd(12'h325, 64'h7000_0000_0000_0005, 1'b0, 1'b0);

      // 40-bit wrap, OF and irq timing
      wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      rd(12'hB03, 64'h0000_00FF_FFFF_FFFF, 1'b0, 1'b0);
      @(posedge phi2);
      #1 events = 8'h02;
      rd(12'h323, 64'h8000_0000_0000_0002, 1'b0, 1'b0);
      rd(12'hB03, 64'd0, 1'b0, 1'b1);
      wr(12'h323, 64'd2, 1'b0, 1'b1);
      rd(12'h323, 64'd2, 1'b0, 1'b0);

      // OF-clearing write in the wrap cycle wins; counter write beats increment
      wr(12'hB03, 64'h0000_00FF_FFFF_FFFF, 1'b0, 1'b0);
      acc(1'b0, 1'b1, 12'h323, 64'd2, 8'h02, 64'd0, 1'b0, 1'b1, 1'b0);
      rd(12'hB03, 64'd0, 1'b0, 1'b0);
      rd(12'h323, 64'd2, 1'b0, 1'b0);
      acc(1'b0, 1'b1, 12'hB03, 64'd50, 8'h02, 64'd0, 1'b0, 1'b1, 1'b0);
      rd(12'hB03, 64'd50, 1'b0, 1'b0);

      // mode filter: UINH set
      wr(12'h323, 64'h1000_0000_0000_0002, 1'b0, 1'b0);
      priv_level = 2'd0;
      pulse(8'h02, 3);
      priv_level = 2'd1;
      pulse(8'h02, 1);
      priv_level = 2'd3;
      rd(12'hB03, 64'd51, 1'b0, 1'b0);
      pulse(8'h02, 2);
      rd(12'hB03, 64'd53, 1'b0, 1'b0);

      // access gating
      wr(12'h306, 64'd1, 1'b0, 1'b0);
      priv_level = 2'd0;
      rd(12'hC00, 64'd0, 1'b1, 1'b0);
      priv_level = 2'd3;
      wr(12'h106, 64'd1, 1'b0, 1'b0);
      priv_level = 2'd0;
      rd(12'hC00, 64'd8, 1'b0, 1'b0);
      rd(12'hC02, 64'd0, 1'b1, 1'b0);
      wr(12'hC00, 64'd5, 1'b1, 1'b0);
      priv_level = 2'd1;
      rd(12'hB00, 64'd0, 1'b1, 1'b0);
      rd(12'h106, 64'd1, 1'b0, 1'b0);
      rd(12'hC01, 64'd0, 1'b1, 1'b0);
      wr(12'h323, 64'd0, 1'b1, 1'b0);
      priv_level = 2'd3;
      rd(12'h323, 64'h1000_0000_0000_0002, 1'b0, 1'b0);
      wr(12'hC00, 64'd5, 1'b1, 1'b0);
      wr(12'h306, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      rd(12'h306, 64'h7F, 1'b0, 1'b0);
      rd(12'hC01, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);

      // minstret write-vs-retire collision
      wr(12'h320, 64'd1, 1'b0, 1'b0);
      retire = 1'b1;
      wr(12'hB02, 64'd100, 1'b0, 1'b0);
      retire = 1'b0;
      rd(12'hB02, 64'd100, 1'b0, 1'b0);
      retire = 1'b1;
      repeat (3) @(posedge phi2);
      #1 retire = 1'b0;
      rd(12'hB02, 64'd103, 1'b0, 1'b0);
      rd(12'hB00, 64'd8, 1'b0, 1'b0);

      // unimplemented and unmapped addresses
      rd(12'hB1F, 64'd0, 1'b0, 1'b0);
      rd(12'h33F, 64'd0, 1'b0, 1'b0);
      rd(12'hB07, 64'd0, 1'b0, 1'b0);
      acc(1'b1, 1'b0, 12'hB01, 64'd0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0);
      acc(1'b1, 1'b0, 12'h7C0, 64'd0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge phi2);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
